// File: rtl/arbitro_pkg.sv
// ----------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the two-requester burst arbiter (arbitro_mux32b):
//   - default data width and default burst limit
//   - FSM state encoding and the "last served requester" flag type
// Optional feature: the burst limit is only built when ARBITRO_LIMITE_EN is
// defined.
// ----------------------------------------------------------------------------
package arbitro_pkg;

    localparam int DATA_WIDTH_PADRAO    = 32;
    localparam int LIMITE_RAJADA_PADRAO = 8;

    // Wide enough for the largest legal burst limit (255).
    localparam int CONTADOR_W = 8;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SERVE1 = 2'd1,
        SERVE2 = 2'd2
    } estado_t;

    // Which requester held the most recent grant; ties go to the other one.
    typedef enum logic {
        SERVIDO2 = 1'b0,
        SERVIDO1 = 1'b1
    } servido_t;

endpackage

// File: rtl/arbitro_mux32b_if.sv
// ----------------------------------------------------------------------------
// arbitro_mux32b_if
// Bundles the two requester handshakes and the downstream output stage.
//   req1/req2       requester k has a beat to send
//   dado1/dado2     requester k data, valid while reqk is high
//   ultimo1/ultimo2 current beat of requester k closes its burst
//   aceite1/aceite2 beat of requester k accepted this cycle
//   saida           registered output data
//   saida_valida    saida holds an unconsumed beat
//   pronto          downstream consumes saida when saida_valida && pronto
//   selecao         registered mux select (1 = requester 1)
// Modports: master = requesters + downstream side, slave = the arbiter.
// ----------------------------------------------------------------------------
interface arbitro_mux32b_if #(
    parameter int DATA_WIDTH = arbitro_pkg::DATA_WIDTH_PADRAO
);
    logic                  req1;
    logic                  req2;
    logic [DATA_WIDTH-1:0] dado1;
    logic [DATA_WIDTH-1:0] dado2;
    logic                  ultimo1;
    logic                  ultimo2;
    logic                  aceite1;
    logic                  aceite2;
    logic [DATA_WIDTH-1:0] saida;
    logic                  saida_valida;
    logic                  pronto;
    logic                  selecao;

    modport master (
        output req1, req2, dado1, dado2, ultimo1, ultimo2, pronto,
        input  aceite1, aceite2, saida, saida_valida, selecao
    );

    modport slave (
        input  req1, req2, dado1, dado2, ultimo1, ultimo2, pronto,
        output aceite1, aceite2, saida, saida_valida, selecao
    );
endinterface

// File: rtl/arbitro_mux32b_mux.sv
// ----------------------------------------------------------------------------
// mux32b
// Two-input data multiplexer used by the arbiter's data path.
//   entrada1, entrada2  data inputs
//   selecao             1 selects entrada1, 0 selects entrada2
//   saida               selected data
// ----------------------------------------------------------------------------
module mux32b
    import arbitro_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_PADRAO
) (
    input  logic [DATA_WIDTH-1:0] entrada1,
    input  logic [DATA_WIDTH-1:0] entrada2,
    input  logic                  selecao,
    output logic [DATA_WIDTH-1:0] saida
);

    assign saida = selecao ? entrada1 : entrada2;

endmodule

// File: rtl/arbitro_mux32b.sv
// ----------------------------------------------------------------------------
// arbitro_mux32b
// Two-requester burst arbiter feeding a single registered output stage.
// A grant lasts for a whole burst (until an accepted beat flagged ultimo, or
// until the owner drops its request); ties from idle go to the requester that
// was not served last.
// Ports:
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      arbitro_mux32b_if.slave (requester handshakes + output stage)
// Parameters:
//   DATA_WIDTH     data path width
//   LIMITE_RAJADA  max beats per grant while the other requester waits
//                  (1..255), only used when ARBITRO_LIMITE_EN is defined
// Build option ARBITRO_LIMITE_EN: adds a beat counter that preempts a long
// burst after LIMITE_RAJADA beats if the other requester is waiting.
// ----------------------------------------------------------------------------
module arbitro_mux32b
    import arbitro_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_PADRAO,
    parameter int LIMITE_RAJADA = LIMITE_RAJADA_PADRAO
) (
    input logic             clock,
    input logic             reset_n,
    arbitro_mux32b_if.slave bus
);

    estado_t               estado_q, estado_d;
    servido_t              servido_q, servido_d;
    logic                  selecao_q;
    logic [DATA_WIDTH-1:0] saida_q, saida_d;
    logic                  valida_q, valida_d;

    logic                  livre;
    logic                  aceite1, aceite2, aceite;
    logic                  limite1, limite2;
    logic                  fim1, fim2;
    logic [DATA_WIDTH-1:0] dado_mux;

    // selecao_q is loaded with (next state == SERVE1), so it always equals
    // (estado_q == SERVE1) and can drive the mux directly.
    mux32b #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .entrada1 (bus.dado1),
        .entrada2 (bus.dado2),
        .selecao  (selecao_q),
        .saida    (dado_mux)
    );

    // The output register can take a beat when empty or drained this cycle.
    assign livre   = !valida_q || bus.pronto;
    assign aceite1 = (estado_q == SERVE1) && bus.req1 && livre;
    assign aceite2 = (estado_q == SERVE2) && bus.req2 && livre;
    assign aceite  = aceite1 || aceite2;

`ifdef ARBITRO_LIMITE_EN
    // Counter holds (accepts so far in this grant); the beat that brings it
    // to LIMITE_RAJADA closes the burst if the other requester is waiting.
    localparam logic [CONTADOR_W-1:0] ULTIMO_BEAT = CONTADOR_W'(LIMITE_RAJADA - 1);

    logic [CONTADOR_W-1:0] contagem_q, contagem_d;

    assign limite1 = bus.req2 && (contagem_q >= ULTIMO_BEAT);
    assign limite2 = bus.req1 && (contagem_q >= ULTIMO_BEAT);
`else
    assign limite1 = 1'b0;
    assign limite2 = 1'b0;
    wire [CONTADOR_W-1:0] unused_limite = CONTADOR_W'(LIMITE_RAJADA);
`endif

    assign fim1 = aceite1 && (bus.ultimo1 || limite1);
    assign fim2 = aceite2 && (bus.ultimo2 || limite2);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        estado_d  = estado_q;
        servido_d = servido_q;
        saida_d   = saida_q;
        valida_d  = valida_q;

        unique case (estado_q)
            OCIOSO: begin
                if (bus.req1 && bus.req2)
                    estado_d = (servido_q == SERVIDO1) ? SERVE2 : SERVE1;
                else if (bus.req1)
                    estado_d = SERVE1;
                else if (bus.req2)
                    estado_d = SERVE2;
            end
            SERVE1: begin
                if (fim1) begin
                    servido_d = SERVIDO1;
                    estado_d  = bus.req2 ? SERVE2 : OCIOSO;
                end else if (!bus.req1) begin
                    // Abandoned burst: release the grant.
                    servido_d = SERVIDO1;
                    estado_d  = OCIOSO;
                end
            end
            SERVE2: begin
                if (fim2) begin
                    servido_d = SERVIDO2;
                    estado_d  = bus.req1 ? SERVE1 : OCIOSO;
                end else if (!bus.req2) begin
                    servido_d = SERVIDO2;
                    estado_d  = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase

        // A new beat replaces a consumed one in the same cycle; otherwise a
        // consumed beat empties the stage and a stalled beat is held.
        if (aceite) begin
            saida_d  = dado_mux;
            valida_d = 1'b1;
        end else if (bus.pronto) begin
            valida_d = 1'b0;
        end

`ifdef ARBITRO_LIMITE_EN
        contagem_d = contagem_q;
        if (estado_d != estado_q)
            contagem_d = '0;
        else if (aceite && (contagem_q != '1))
            contagem_d = contagem_q + CONTADOR_W'(1);
`endif
    end

    // NOTE: state is only ever updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            servido_q  <= SERVIDO2;
            selecao_q  <= 1'b0;
            saida_q    <= '0;
            valida_q   <= 1'b0;
`ifdef ARBITRO_LIMITE_EN
            contagem_q <= '0;
`endif
        end else begin
            estado_q   <= estado_d;
            servido_q  <= servido_d;
            selecao_q  <= (estado_d == SERVE1);
            saida_q    <= saida_d;
            valida_q   <= valida_d;
`ifdef ARBITRO_LIMITE_EN
            contagem_q <= contagem_d;
`endif
        end
    end

    assign bus.aceite1      = aceite1;
    assign bus.aceite2      = aceite2;
    assign bus.saida        = saida_q;
    assign bus.saida_valida = valida_q;
    assign bus.selecao      = selecao_q;

endmodule

// File: tb/tb_arbitro_mux32b.sv
// ----------------------------------------------------------------------------
// tb_arbitro_mux32b
// Self-checking bench for arbitro_mux32b: directed scenarios followed by
// random requester/downstream traffic, all compared against a grant-level
// reference model plus an in-order scoreboard of accepted beats.
// Honours ARBITRO_LIMITE_EN (burst limit set to 2 here).
// ----------------------------------------------------------------------------
module tb_arbitro_mux32b;
    import arbitro_pkg::*;

    localparam int DW  = 32;
    localparam int LIM = 2;
`ifdef ARBITRO_LIMITE_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    arbitro_mux32b_if #(.DATA_WIDTH(DW)) bus ();

    arbitro_mux32b #(
        .DATA_WIDTH    (DW),
        .LIMITE_RAJADA (LIM)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          ref_dono;     // 0 = nobody, 1 or 2 = requester holding the grant
    int          ref_ultimo;   // requester served most recently
    int          ref_beats;    // beats accepted in the current grant
    logic [31:0] ref_saida;
    bit          ref_valida;
    bit          ref_ac1, ref_ac2;
    logic [31:0] sb_q[$];      // accepted beats not yet consumed, in order
    logic [31:0] vistos[$];    // every valid saida seen at a sample point
    logic [31:0] consumidos[$];

    task automatic ref_reset();
        ref_dono   = 0;
        ref_ultimo = 2;
        ref_beats  = 0;
        ref_saida  = '0;
        ref_valida = 1'b0;
        ref_ac1    = 1'b0;
        ref_ac2    = 1'b0;
        sb_q.delete();
    endtask

    // One clock: compare at the falling edge, advance the model, then return
    // just after the rising edge so the caller can drive new inputs.
    task automatic step();
        bit          livre, ac, rk, ro, ult;
        logic [63:0] esperado;
        @(negedge clock);
        livre   = !ref_valida || bus.pronto;
        ref_ac1 = (ref_dono == 1) && bus.req1 && livre;
        ref_ac2 = (ref_dono == 2) && bus.req2 && livre;

        check("selecao", bus.selecao, ref_dono == 1);
        check("saida_valida", bus.saida_valida, ref_valida);
        check("saida", bus.saida, ref_saida);
        check("aceite1", bus.aceite1, ref_ac1);
        check("aceite2", bus.aceite2, ref_ac2);

        if (bus.saida_valida) vistos.push_back(bus.saida);
        if (bus.saida_valida && bus.pronto) begin
            esperado = (sb_q.size() != 0) ? {32'h0, sb_q.pop_front()} : {32'hFFFF_FFFF, 32'h0};
            check("ordem_saida", bus.saida, esperado);
            consumidos.push_back(bus.saida);
        end

        if (ref_ac1 || ref_ac2) begin
            ref_saida  = ref_ac1 ? bus.dado1 : bus.dado2;
            ref_valida = 1'b1;
            sb_q.push_back(ref_saida);
        end else if (bus.pronto) begin
            ref_valida = 1'b0;
        end

        if (ref_dono == 0) begin
            if (bus.req1 && bus.req2) ref_dono = (ref_ultimo == 1) ? 2 : 1;
            else if (bus.req1)        ref_dono = 1;
            else if (bus.req2)        ref_dono = 2;
            ref_beats = 0;
        end else begin
            ac  = (ref_dono == 1) ? ref_ac1 : ref_ac2;
            rk  = (ref_dono == 1) ? bus.req1 : bus.req2;
            ro  = (ref_dono == 1) ? bus.req2 : bus.req1;
            ult = (ref_dono == 1) ? bus.ultimo1 : bus.ultimo2;
            if (ac) begin
                ref_beats++;
                if (ult || (LIM_EN && ref_beats >= LIM && ro)) begin
                    ref_ultimo = ref_dono;
                    ref_dono   = ro ? 3 - ref_dono : 0;
                    ref_beats  = 0;
                end
            end else if (!rk) begin
                ref_ultimo = ref_dono;
                ref_dono   = 0;
                ref_beats  = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        bus.req1   = 1'b0;
        bus.req2   = 1'b0;
        bus.pronto = 1'b1;
        repeat (3) step();
    endtask

    // ---------------- random requesters ----------------
    int rem[1:2];
    int seq[1:2];

    task automatic gen_inputs();
        bit ac[1:2];
        ac[1] = ref_ac1;
        ac[2] = ref_ac2;
        for (int k = 1; k <= 2; k++) begin
            if (ac[k]) begin
                rem[k]--;
                seq[k]++;
            end
            if (rem[k] == 0) begin
                if ($urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 6);
            end else if (!ac[k] && $urandom_range(0, 39) == 0) begin
                rem[k] = 0;   // abandon the burst
            end
        end
        bus.req1    = (rem[1] != 0);
        bus.dado1   = 32'h1000_0000 + 32'(seq[1]);
        bus.ultimo1 = (rem[1] == 1);
        bus.req2    = (rem[2] != 0);
        bus.dado2   = 32'h2000_0000 + 32'(seq[2]);
        bus.ultimo2 = (rem[2] == 1);
        bus.pronto  = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [31:0] rajada[3];
        bit          prontos[8];
        int          idx, n_11, n1, n1_antes;
        bit          feito2;
        int          ordem[$];

        reset_n     = 1'b0;
        bus.req1    = 1'b0;
        bus.req2    = 1'b0;
        bus.dado1   = '0;
        bus.dado2   = '0;
        bus.ultimo1 = 1'b0;
        bus.ultimo2 = 1'b0;
        bus.pronto  = 1'b0;
        ref_reset();

        #2;
        check("reset_saida_valida", bus.saida_valida, 0);
        check("reset_selecao", bus.selecao, 0);
        check("reset_saida", bus.saida, 0);
        check("reset_aceite1", bus.aceite1, 0);
        #10 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single beat from requester 1.
        bus.req1    = 1'b1;
        bus.dado1   = 32'hAAAA_0001;
        bus.ultimo1 = 1'b1;
        bus.pronto  = 1'b1;
        step();                                   // grant
        check("simples_aceite1", bus.aceite1, 1);
        step();                                   // accept
        bus.req1 = 1'b0;
        check("simples_saida", bus.saida, 32'hAAAA_0001);
        check("simples_valida", bus.saida_valida, 1);
        check("simples_ocioso", bus.selecao, 0);
        step();
        drain();

        // Requester 2 burst with a two-cycle stall on its second beat.
        rajada  = '{32'h10, 32'h11, 32'h12};
        prontos = '{1, 1, 1, 0, 0, 1, 1, 1};
        vistos.delete();
        consumidos.delete();
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req2    = (idx < 3);
            bus.dado2   = rajada[(idx < 3) ? idx : 2];
            bus.ultimo2 = (idx == 2);
            bus.pronto  = prontos[i];
            step();
            if (ref_ac2) idx++;
        end
        n_11 = 0;
        foreach (vistos[j]) if (vistos[j] == 32'h11) n_11++;
        check("parada_retencao_11", n_11, 3);
        check("parada_n_consumidos", consumidos.size(), 3);
        for (int j = 0; j < 3; j++)
            check("parada_ordem", (j < consumidos.size()) ? consumidos[j] : 32'hFFFF_FFFF, rajada[j]);
        drain();

        // Requester 1 abandons its burst while requester 2 waits.
        bus.req1    = 1'b1;
        bus.dado1   = 32'h3000_0000;
        bus.ultimo1 = 1'b0;
        bus.pronto  = 1'b1;
        step();
        step();                                   // one beat accepted
        bus.req1    = 1'b0;
        bus.req2    = 1'b1;
        bus.dado2   = 32'h3000_0002;
        bus.ultimo2 = 1'b1;
        step();                                   // SERVE1 -> OCIOSO
        check("abandono_ocioso_sel", bus.selecao, 0);
        check("abandono_ocioso_ac2", bus.aceite2, 0);
        step();                                   // OCIOSO -> SERVE2
        check("abandono_serve2_ac2", bus.aceite2, 1);
        step();
        drain();

        // Long burst from requester 1 while requester 2 waits.
        n1       = 0;
        n1_antes = -1;
        feito2   = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.req1    = (n1 < 5);
            bus.dado1   = 32'h4000_0000 + 32'(n1);
            bus.ultimo1 = (n1 == 4);
            bus.req2    = (i >= 1) && !feito2;
            bus.dado2   = 32'h4000_00FF;
            bus.ultimo2 = 1'b1;
            bus.pronto  = 1'b1;
            step();
            if (ref_ac2 && !feito2) begin
                feito2   = 1'b1;
                n1_antes = n1;
            end
            if (ref_ac1) n1++;
        end
        check("limite_beats_antes_2", n1_antes, LIM_EN ? 2 : 5);
        check("limite_total_1", n1, 5);
        drain();

        // Asynchronous reset in the middle of a burst with a pending beat.
        bus.req1    = 1'b1;
        bus.dado1   = 32'h5000_0000;
        bus.ultimo1 = 1'b0;
        bus.pronto  = 1'b0;
        step();
        step();                                   // beat now pending in saida
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_valida", bus.saida_valida, 0);
        check("rst_async_selecao", bus.selecao, 0);
        check("rst_async_saida", bus.saida, 0);
        check("rst_async_aceite1", bus.aceite1, 0);
        bus.req1 = 1'b0;
        ref_reset();
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Both requesting single beats from reset: grants alternate 1,2,1,2.
        bus.req1    = 1'b1;
        bus.req2    = 1'b1;
        bus.ultimo1 = 1'b1;
        bus.ultimo2 = 1'b1;
        bus.pronto  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.dado1 = 32'h6100_0000 + 32'(i);
            bus.dado2 = 32'h6200_0000 + 32'(i);
            step();
            if (ref_ac1) ordem.push_back(1);
            if (ref_ac2) ordem.push_back(2);
        end
        for (int j = 0; j < 4; j++)
            check("alterna_ordem", (j < ordem.size()) ? ordem[j] : 0, (j % 2 == 0) ? 1 : 2);
        drain();

        // Random traffic.
        rem[1] = 0;
        rem[2] = 0;
        seq[1] = 0;
        seq[2] = 0;
        ref_ac1 = 1'b0;
        ref_ac2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            gen_inputs();
            step();
        end
        drain();
        check("final_sb_vazio", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
